// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampled UART receiver with 2-flop line synchronizer,
//                centre-of-bit sampling, done and framing-error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int NB_TICK = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxDone,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int c_TICK_MAX = (NB_TICK > SB_TICK) ? NB_TICK : SB_TICK;
    localparam int c_TICK_W   = $clog2(c_TICK_MAX);
    localparam int c_BIT_W    = $clog2(NB_DATA) + 1;

    localparam logic [c_TICK_W-1:0] c_HALF_TICK = c_TICK_W'(NB_TICK / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_DATA_TICK = c_TICK_W'(NB_TICK - 1);
    localparam logic [c_TICK_W-1:0] c_STOP_TICK = c_TICK_W'(SB_TICK - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_line;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_TICK_W-1:0]  w_tick_cnt_next;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_BIT_W-1:0]   w_bit_cnt_next;
    logic [NB_DATA-1:0]   r_shift;
    logic [NB_DATA-1:0]   w_shift_next;
    logic [NB_DATA-1:0]   r_data;
    logic                 r_rx_done;
    logic                 r_frame_err;
    logic                 w_done;
    logic                 w_ferr;

    assign w_line = r_sync2;

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_done          = 1'b0;
        w_ferr          = 1'b0;
        case (r_state)
            IDLE: begin
                // Start detection is tick-independent so back-to-back frames lose no cycle
                if (!w_line) begin
                    w_state_next    = START;
                    w_tick_cnt_next = '0;
                    w_bit_cnt_next  = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_HALF_TICK) begin
                        w_tick_cnt_next = '0;
                        w_state_next    = w_line ? IDLE : DATA;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_DATA_TICK) begin
                        w_tick_cnt_next = '0;
                        w_shift_next    = {w_line, r_shift[NB_DATA-1:1]};
                        w_bit_cnt_next  = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_STOP_TICK) begin
                        w_tick_cnt_next = '0;
                        w_state_next    = IDLE;
                        w_done          = w_line;
                        w_ferr          = ~w_line;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_tick_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= i_rx;
            r_sync2     <= r_sync1;
            r_state     <= w_state_next;
            r_tick_cnt  <= w_tick_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_rx_done   <= w_done;
            r_frame_err <= w_ferr;
            if (w_done) begin
                r_data <= r_shift;
            end
        end
    end

    assign o_data      = r_data;
    assign o_rxDone    = r_rx_done;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx using a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rxDone;
    logic       o_frame_err;
    logic       o_busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] done_q[$];
    logic [7:0] exp_q[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         exp_ferr = 0;
    logic [7:0] last_good = 8'h00;
    logic [1:0] tick_div = 2'd0;

    uart_rx #(
        .NB_DATA (8),
        .SB_TICK (16),
        .NB_TICK (16)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rxDone    (o_rxDone),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks: 16 ticks per bit gives 64 clocks per bit
    always @(negedge clk) begin
        tick_div = tick_div + 2'd1;
        i_tick   = (tick_div == 2'd0);
    end

    always @(negedge clk) begin
        if (o_rxDone === 1'b1) done_q.push_back(o_data);
        if (o_frame_err === 1'b1) ferr_cnt++;
        if (o_rxDone === 1'b1 && o_frame_err === 1'b1) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        i_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Serial frame: start, LSB-first data, stop. A bad stop is held low across
    // its sample point and then released so the line does not restart a frame.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int cpb);
        drive(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(d[i], cpb);
        if (stop_ok) begin
            drive(1'b1, cpb);
            exp_q.push_back(d);
            last_good = d;
        end else begin
            drive(1'b0, (cpb * 3) / 4);
            drive(1'b1, 2 * cpb);
            exp_ferr++;
        end
    endtask

    task automatic verify(input string tag);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
        chk({tag, "_ndone"}, 32'(done_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < done_q.size(); i++)
            chk($sformatf("%s_data%0d", tag, i), 32'(done_q[i]), 32'(exp_q[i]));
        chk({tag, "_nferr"}, 32'(ferr_cnt), 32'(exp_ferr));
        chk({tag, "_both"}, 32'(both_cnt), 32'd0);
        chk({tag, "_odata"}, 32'(o_data), 32'(last_good));
        done_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
        both_cnt = 0;
        exp_ferr = 0;
    endtask

    initial begin
        logic [7:0] d;
        bit         ok;
        int         cpb;

        repeat (5) @(negedge clk);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_done", 32'(o_rxDone), 32'd0);
        chk("rst_ferr", 32'(o_frame_err), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;
        drive(1'b1, 20);

        send_frame(8'h08, 1'b1, 64);
        verify("single08");

        send_frame(8'h10, 1'b1, 64);
        send_frame(8'h20, 1'b1, 64);
        send_frame(8'h05, 1'b1, 64);
        verify("b2b");

        drive(1'b0, 12);
        drive(1'b1, 64);
        verify("glitch");

        send_frame(8'hA5, 1'b0, 64);
        drive(1'b1, 64);
        verify("stoplow");

        // Abort 0xFF in the middle of data bit 4
        drive(1'b0, 64);
        drive(1'b1, 4 * 64 + 32);
        i_rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_rst_data", 32'(o_data), 32'd0);
        chk("abort_rst_busy", 32'(o_busy), 32'd0);
        last_good = 8'h00;
        i_rst = 1'b0;
        drive(1'b1, 400);
        verify("abort");
        send_frame(8'h3C, 1'b1, 64);
        verify("after_abort");

        // Line already low at reset release: START after two sync stages
        i_rx = 1'b0;
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rel_low_sync", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("rel_low_start", 32'(o_busy), 32'd1);
        last_good = 8'h00;
        drive(1'b1, 100);
        verify("rel_low");

        send_frame(8'h81, 1'b1, 62);
        verify("skew_fast");
        send_frame(8'h81, 1'b1, 66);
        verify("skew_slow");

        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            cpb = ok ? 62 + 2 * int'($urandom_range(0, 2)) : 64;
            send_frame(d, ok, cpb);
            if ($urandom_range(0, 1) == 1) drive(1'b1, int'($urandom_range(1, 40)));
        end
        verify("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
